// File: rtl/rr_hand_pkg.sv
// Shared helpers for the round-robin arbiter/dispatcher pair: FSM state
// encoding, pointer width and pointer wrap.
package rr_hand_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } rr_state_e;

  // Minimum 1 bit so a degenerate port count still yields a legal vector.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned ptr_wrap_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one finder: lowest set bit of mask at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick
  import rr_hand_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[(int'(ptr) + i) % N]) begin
        idx   = W'((int'(ptr) + i) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_dispatcher_hand.sv
// Packet-level round-robin splitter: one valid/ready/last stream fanned out
// to REQ_NUM ports, whole packets per port, one registered output stage.
module round_robin_dispatcher_hand
  import rr_hand_pkg::*;
#(
  parameter int REQ_NUM = 8,
  parameter int DATA_W  = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [REQ_NUM-1:0] port_en,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               last_in,
  output logic [REQ_NUM-1:0] valid_out,
  input  logic [REQ_NUM-1:0] ready_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               last_out,
  output logic               busy
);

  localparam int PTR_W = ptr_w(REQ_NUM);

  rr_state_e         state, state_d;
  logic [PTR_W-1:0]  ptr, ptr_d, cur, cur_d;
  logic [PTR_W-1:0]  pick, tgt, sel_r;
  logic              found, locked;
  logic              vld_r, last_r;
  logic [DATA_W-1:0] data_r;
  logic              fire_in, out_fire;

  rr_pick #(.N(REQ_NUM), .W(PTR_W)) u_pick (
    .mask  (port_en),
    .ptr   (ptr),
    .idx   (pick),
    .found (found)
  );

  assign locked   = (state == PKT);
  assign tgt      = locked ? cur : pick;
  assign out_fire = vld_r && ready_out[sel_r];
  // Accept when a target exists and the output slot is free or draining now.
  assign ready_in = (locked || found) && (!vld_r || ready_out[sel_r]);
  assign fire_in  = valid_in && ready_in;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cur_d   = cur;
    case (state)
      IDLE: if (fire_in) begin
        if (last_in) ptr_d = PTR_W'(ptr_wrap_inc(32'(pick), REQ_NUM));
        else begin
          state_d = PKT;
          cur_d   = pick;
        end
      end
      PKT: if (fire_in && last_in) begin
        state_d = IDLE;
        ptr_d   = PTR_W'(ptr_wrap_inc(32'(cur), REQ_NUM));
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ptr   <= '0;
      cur   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      cur   <= cur_d;
    end
  end

  // Output stage: payload holds after drain; only the valid bit clears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_r  <= 1'b0;
      sel_r  <= '0;
      data_r <= '0;
      last_r <= 1'b0;
    end else if (fire_in) begin
      vld_r  <= 1'b1;
      sel_r  <= tgt;
      data_r <= data_in;
      last_r <= last_in;
    end else if (out_fire) begin
      vld_r  <= 1'b0;
    end
  end

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_vld
    assign valid_out[i] = vld_r && (sel_r == PTR_W'(i));
  end

  assign data_out = data_r;
  assign last_out = last_r;
  assign busy     = locked;

endmodule
